// File: rtl/elevator_pkg.sv
// Shared constants, state encoding and call-scan helpers for the elevator car.
package elevator_pkg;

    localparam logic ON    = 1'b1;
    localparam logic OFF   = 1'b0;
    localparam logic MOVE  = 1'b1;
    localparam logic HOLD  = 1'b0;
    localparam logic OPEN  = 1'b1;
    localparam logic CLOSE = 1'b0;

    localparam logic [1:0] STOP   = 2'b00;
    localparam logic [1:0] UP     = 2'b10;
    localparam logic [1:0] DOWN   = 2'b01;
    localparam logic [1:0] UPDOWN = 2'b11;

    localparam logic [2:0] BOTTOM_FLOOR = 3'd1;
    localparam logic [2:0] TOP_FLOOR    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MOVE,
        S_ARRIVE,
        S_DOOR_OPEN
    } seqState_t;

    function automatic logic isIn(input logic [2:0] floor);
        return floor != 3'd0;
    endfunction

    // Hall bit positions for floor f: up = 2f-1, down = 2f-2.
    function automatic logic [3:0] hallUpIdx(input logic [2:0] cf);
        return {cf, 1'b0} - 4'd1;
    endfunction

    function automatic logic [3:0] hallDownIdx(input logic [2:0] cf);
        return {cf, 1'b0} - 4'd2;
    endfunction

    function automatic logic callsAbove(input logic [2:0] cf, input logic [13:0] fb,
                                        input logic [9:1] ib);
        logic r;
        r = 1'b0;
        for (int unsigned f = 1; f <= 7; f++) begin
            if (3'(f) > cf) r = r | ib[4'(f)] | fb[4'(2 * f - 1)] | fb[4'(2 * f - 2)];
        end
        return r;
    endfunction

    function automatic logic callsBelow(input logic [2:0] cf, input logic [13:0] fb,
                                        input logic [9:1] ib);
        logic r;
        r = 1'b0;
        for (int unsigned f = 1; f <= 7; f++) begin
            if (3'(f) < cf) r = r | ib[4'(f)] | fb[4'(2 * f - 1)] | fb[4'(2 * f - 2)];
        end
        return r;
    endfunction

endpackage

// File: rtl/call_scanner.sv
// Combinational view of pending calls relative to a floor: at it, above it, below it.
module call_scanner
    import elevator_pkg::*;
(
    input  logic [2:0]  cf,
    input  logic [13:0] floorButton,
    input  logic [9:1]  internalButton,
    output logic        here,
    output logic        above,
    output logic        below
);

    assign here  = internalButton[{1'b0, cf}] | floorButton[hallUpIdx(cf)]
                 | floorButton[hallDownIdx(cf)];
    assign above = callsAbove(cf, floorButton, internalButton);
    assign below = callsBelow(cf, floorButton, internalButton);

endmodule

// File: rtl/car_sequencer.sv
// Elevator car sequencer: travel timing, stop decisions, door dwell and button clears.
module car_sequencer
    import elevator_pkg::*;
#(
    parameter int FLOOR_TICKS = 16,
    parameter int DOOR_TICKS  = 32,
    parameter int TW          = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  nextDirection,
    input  logic [13:0] floorButton,
    input  logic [9:1]  internalButton,
    output logic [2:0]  currentFloor,
    output logic [1:0]  currentDirection,
    output logic        move,
    output logic        doorState,
    output logic [13:0] clearFloor,
    output logic [9:1]  clearInternal,
    output logic        fault
);

    seqState_t       state, stateNext;
    logic [2:0]      cf, cfNext, stepFloor;
    logic [1:0]      dir, dirNext;
    logic            moveR, moveNext, doorR, doorNext, faultR, faultNext;
    logic [13:0]     clrF, clrFNext, fbEff;
    logic [9:1]      clrI, clrINext, ibEff;
    logic [TW-1:0]   floorTimer, floorTimerNext, doorTimer, doorTimerNext;
    logic            here, callAbove, callBelow;
    logic            goingUp, ahead, atEnd, stopHere;
    logic [3:0]      cfIdx, upIdx, downIdx, matchIdx, oppIdx;

    // A call whose clear pulse is in flight is still visible at the latch this
    // cycle; masking it stops it re-triggering a restart or a second pulse.
    assign fbEff = floorButton & ~clrF;
    assign ibEff = internalButton & ~clrI;

    call_scanner scanner (
        .cf             (cf),
        .floorButton    (fbEff),
        .internalButton (ibEff),
        .here           (here),
        .above          (callAbove),
        .below          (callBelow)
    );

    assign cfIdx    = {1'b0, cf};
    assign upIdx    = hallUpIdx(cf);
    assign downIdx  = hallDownIdx(cf);
    assign goingUp  = (dir == UP);
    assign matchIdx = goingUp ? upIdx : downIdx;
    assign oppIdx   = goingUp ? downIdx : upIdx;
    assign ahead    = goingUp ? callAbove : callBelow;
    assign atEnd    = goingUp ? (cf == TOP_FLOOR) : (cf == BOTTOM_FLOOR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cf         <= BOTTOM_FLOOR;
            dir        <= STOP;
            moveR      <= HOLD;
            doorR      <= CLOSE;
            faultR     <= OFF;
            clrF       <= '0;
            clrI       <= '0;
            floorTimer <= '0;
            doorTimer  <= '0;
        end else begin
            state      <= stateNext;
            cf         <= cfNext;
            dir        <= dirNext;
            moveR      <= moveNext;
            doorR      <= doorNext;
            faultR     <= faultNext;
            clrF       <= clrFNext;
            clrI       <= clrINext;
            floorTimer <= floorTimerNext;
            doorTimer  <= doorTimerNext;
        end
    end

    always_comb begin
        stateNext      = state;
        cfNext         = cf;
        dirNext        = dir;
        moveNext       = moveR;
        doorNext       = doorR;
        faultNext      = faultR;
        floorTimerNext = floorTimer;
        doorTimerNext  = doorTimer;
        clrFNext       = '0;
        clrINext       = '0;
        stepFloor      = goingUp ? cf + 3'd1 : cf - 3'd1;
        stopHere       = ibEff[cfIdx] | fbEff[matchIdx] | !ahead | atEnd;
        case (state)
            S_IDLE: begin
                moveNext = HOLD;
                doorNext = CLOSE;
                if (here || ibEff[8]) begin
                    stateNext        = S_DOOR_OPEN;
                    doorNext         = OPEN;
                    doorTimerNext    = '0;
                    clrINext[cfIdx]  = ON;
                    clrFNext[upIdx]  = ON;
                    clrFNext[downIdx] = ON;
                end else begin
                    stateNext = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (nextDirection == UPDOWN) begin
                    faultNext = ON;
                    dirNext   = STOP;
                end else begin
                    dirNext = nextDirection;
                end
                if ((nextDirection == UP && cf != TOP_FLOOR) ||
                    (nextDirection == DOWN && cf != BOTTOM_FLOOR)) begin
                    stateNext      = S_MOVE;
                    moveNext       = MOVE;
                    floorTimerNext = '0;
                end else begin
                    stateNext = S_IDLE;
                end
            end
            S_MOVE: begin
                if (floorTimer == TW'(FLOOR_TICKS - 1)) begin
                    if (isIn(stepFloor)) cfNext = stepFloor;
                    stateNext = S_ARRIVE;
                end else begin
                    floorTimerNext = floorTimer + 1'b1;
                end
            end
            S_ARRIVE: begin
                if (stopHere) begin
                    stateNext          = S_DOOR_OPEN;
                    moveNext           = HOLD;
                    doorNext           = OPEN;
                    doorTimerNext      = '0;
                    clrINext[cfIdx]    = ON;
                    clrFNext[matchIdx] = ON;
                    if (!ahead) clrFNext[oppIdx] = ON;
                end else begin
                    stateNext      = S_MOVE;
                    floorTimerNext = '0;
                end
            end
            S_DOOR_OPEN: begin
                if (ibEff[8] || here) begin
                    doorTimerNext     = '0;
                    clrINext[cfIdx]   = ibEff[cfIdx];
                    clrFNext[upIdx]   = fbEff[upIdx];
                    clrFNext[downIdx] = fbEff[downIdx];
                end else if (ibEff[9] || doorTimer == TW'(DOOR_TICKS - 1)) begin
                    stateNext = S_IDLE;
                    doorNext  = CLOSE;
                end else begin
                    doorTimerNext = doorTimer + 1'b1;
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    assign currentFloor     = cf;
    assign currentDirection = dir;
    assign move             = moveR;
    assign doorState        = doorR;
    assign clearFloor       = clrF;
    assign clearInternal    = clrI;
    assign fault            = faultR;

endmodule

// File: tb/tb_car_sequencer.sv
// Self-checking bench for car_sequencer: directed scenarios plus random trips vs a trip-level model.
module tb_car_sequencer;

    localparam int FT = 16;
    localparam int DT = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  nextDirection;
    logic [13:0] floorButton;
    logic [9:1]  internalButton;
    logic [2:0]  currentFloor;
    logic [1:0]  currentDirection;
    logic        move, doorState, fault;
    logic [13:0] clearFloor;
    logic [9:1]  clearInternal;

    int checks = 0;
    int failures = 0;
    int tbFloor = 1;
    logic [13:0] seenF, prevF;
    logic [9:1]  seenI, prevI;

    car_sequencer #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT), .TW(6)) dut (
        .clk              (clk),
        .reset            (reset),
        .nextDirection    (nextDirection),
        .floorButton      (floorButton),
        .internalButton   (internalButton),
        .currentFloor     (currentFloor),
        .currentDirection (currentDirection),
        .move             (move),
        .doorState        (doorState),
        .clearFloor       (clearFloor),
        .clearInternal    (clearInternal),
        .fault            (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample after the edge, check invariants, then act as the button latches.
    task automatic tick();
        logic [4:0] inv;
        @(posedge clk);
        #1;
        inv[0] = move & doorState;
        inv[1] = (currentFloor == 3'd0);
        inv[2] = move && (clearFloor != '0 || clearInternal != '0);
        inv[3] = ((clearFloor & prevF) != '0) || ((clearInternal & prevI) != '0);
        inv[4] = clearInternal[9] | clearInternal[8];
        check("invariant", 32'(inv), 32'd0);
        seenF = seenF | clearFloor;
        seenI = seenI | clearInternal;
        prevF = clearFloor;
        prevI = clearInternal;
        floorButton    = floorButton & ~clearFloor;
        internalButton = internalButton & ~clearInternal;
    endtask

    function automatic logic fbit(input logic [13:0] v, input int k);
        logic [13:0] t;
        t = v >> k;
        return t[0];
    endfunction

    function automatic logic ibit(input logic [9:1] v, input int f);
        logic [9:1] t;
        t = v >> (f - 1);
        return t[1];
    endfunction

    function automatic logic callAt(input int f, input logic [13:0] fb, input logic [9:1] ib);
        return ibit(ib, f) | fbit(fb, 2 * f - 1) | fbit(fb, 2 * f - 2);
    endfunction

    function automatic logic aheadM(input int f, input int step, input logic [13:0] fb,
                                    input logic [9:1] ib);
        logic r;
        r = 1'b0;
        for (int g = 1; g <= 7; g++)
            if ((step > 0 && g > f) || (step < 0 && g < f)) r = r | callAt(g, fb, ib);
        return r;
    endfunction

    // First floor past s (in travel direction) at which the car must stop.
    function automatic int nextStop(input int s, input int step, input logic [13:0] fb,
                                    input logic [9:1] ib);
        int f;
        f = s;
        for (int n = 0; n < 7; n++) begin
            f = f + step;
            if (ibit(ib, f) || fbit(fb, step > 0 ? 2 * f - 1 : 2 * f - 2) ||
                !aheadM(f, step, fb, ib) || (f == 7 && step > 0) || (f == 1 && step < 0))
                break;
        end
        return f;
    endfunction

    task automatic runTrip(input string tag, input int step, input logic [13:0] addF,
                           input logic [9:1] addI);
        int f, n, cnt, dcnt, k, matchK, oppK;
        logic aheadF, leftover;
        logic [13:0] expF;
        logic [9:1] expI;
        check({tag, ".startFloor"}, 32'(currentFloor), 32'(tbFloor));
        floorButton    = floorButton | addF;
        internalButton = internalButton | addI;
        f      = nextStop(tbFloor, step, floorButton, internalButton);
        n      = (f > tbFloor) ? f - tbFloor : tbFloor - f;
        matchK = step > 0 ? 2 * f - 1 : 2 * f - 2;
        oppK   = step > 0 ? 2 * f - 2 : 2 * f - 1;
        aheadF = aheadM(f, step, floorButton, internalButton);
        leftover = aheadF && fbit(floorButton, oppK);
        expI = 9'(1) << (f - 1);
        expF = 14'(1) << matchK;
        if (!aheadF || leftover) expF = expF | (14'(1) << oppK);
        seenF = '0;
        seenI = '0;
        nextDirection = step > 0 ? 2'b10 : 2'b01;
        k = 0;
        while (!move && k < 10) begin tick(); k++; end
        check({tag, ".moveStart"}, 32'(move), 32'd1);
        nextDirection = 2'b00;
        cnt = 0;
        while (!doorState && cnt < n * (FT + 1) + 20) begin tick(); cnt++; end
        check({tag, ".travelCycles"}, 32'(cnt), 32'(n * (FT + 1)));
        check({tag, ".floor"}, 32'(currentFloor), 32'(f));
        check({tag, ".holdAtStop"}, 32'(move), 32'd0);
        check({tag, ".direction"}, 32'(currentDirection), step > 0 ? 32'd2 : 32'd1);
        dcnt = 1;
        while (doorState && dcnt < DT + 50) begin
            tick();
            if (doorState) dcnt++;
        end
        check({tag, ".doorCycles"}, 32'(dcnt), 32'(DT + (leftover ? 1 : 0)));
        tick();
        tick();
        check({tag, ".clearFloor"}, 32'(seenF), 32'(expF));
        check({tag, ".clearInternal"}, 32'(seenI), 32'(expI));
        tbFloor = f;
    endtask

    // Open from IDLE with [8], then press btn when the door has been open k cycles.
    task automatic doorTrial(input string tag, input int k, input logic [9:8] btn, input int expCycles);
        int w, dcnt;
        seenF = '0;
        seenI = '0;
        internalButton[8] = 1'b1;
        w = 0;
        while (!doorState && w < 10) begin tick(); w++; end
        check({tag, ".opened"}, 32'(doorState), 32'd1);
        internalButton[8] = 1'b0;
        dcnt = 1;
        while (doorState && dcnt < 200) begin
            if (dcnt == k) internalButton[9:8] = btn;
            tick();
            internalButton[9:8] = 2'b00;
            if (doorState) dcnt++;
        end
        check({tag, ".doorCycles"}, 32'(dcnt), 32'(expCycles));
        tick();
        check({tag, ".clearInternal"}, 32'(seenI), 32'(9'(1) << (tbFloor - 1)));
        check({tag, ".clearFloor"}, 32'(seenF),
              32'((14'(1) << (2 * tbFloor - 1)) | (14'(1) << (2 * tbFloor - 2))));
    endtask

    initial begin
        int s, step, k;
        logic [13:0] addF;
        logic [9:1] addI;
        logic sawMove;

        reset = 1'b1;
        nextDirection = 2'b00;
        floorButton = '0;
        internalButton = '0;
        seenF = '0; seenI = '0; prevF = '0; prevI = '0;
        repeat (3) tick();
        check("reset.floor", 32'(currentFloor), 32'd1);
        check("reset.dir", 32'(currentDirection), 32'd0);
        check("reset.moveDoor", 32'({move, doorState}), 32'd0);
        check("reset.clears", 32'({clearFloor, clearInternal}), 32'd0);
        check("reset.fault", 32'(fault), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        runTrip("up5", 1, '0, 9'(1) << 4);
        runTrip("down1", -1, '0, 9'(1));
        runTrip("passHall3", 1, 14'(1) << 4, 9'(1) << 5);
        check("passHall3.stop6", 32'(tbFloor), 32'd6);
        runTrip("downHall3", -1, '0, '0);
        check("downHall3.stop3", 32'(tbFloor), 32'd3);
        runTrip("hallDown5", 1, 14'(1) << 8, '0);
        check("hallDown5.bits9_8", 32'(seenF[9:8]), 32'd3);

        doorTrial("door8", 20, 2'b01, 20 + DT);
        doorTrial("door9", 5, 2'b10, 5);
        doorTrial("door89", 10, 2'b11, 10 + DT);

        for (int t = 0; t < 12; t++) begin
            s = tbFloor;
            if (s == 1) step = 1;
            else if (s == 7) step = -1;
            else step = ($urandom_range(0, 1) == 1) ? 1 : -1;
            addF = '0;
            addI = '0;
            for (int g = 1; g <= 7; g++) begin
                if (g != s) begin
                    if ($urandom_range(0, 4) == 0) addI = addI | (9'(1) << (g - 1));
                    if ($urandom_range(0, 5) == 0) addF = addF | (14'(1) << (2 * g - 1));
                    if ($urandom_range(0, 5) == 0) addF = addF | (14'(1) << (2 * g - 2));
                end
            end
            runTrip($sformatf("rand%0d", t), step, addF, addI);
        end

        while (tbFloor != 1) runTrip("home", -1, '0, 9'(1));

        floorButton = '0;
        internalButton = '0;
        internalButton[7] = 1'b1;
        nextDirection = 2'b10;
        k = 0;
        while (!move && k < 10) begin tick(); k++; end
        nextDirection = 2'b00;
        k = 0;
        while (currentFloor != 3'd4 && k < 200) begin tick(); k++; end
        repeat (3) tick();
        check("midMove.floor4", 32'(currentFloor), 32'd4);
        check("midMove.moving", 32'(move), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("asyncReset.floor", 32'(currentFloor), 32'd1);
        check("asyncReset.moveDoor", 32'({move, doorState}), 32'd0);
        tick();
        check("midReset.floor", 32'(currentFloor), 32'd1);
        check("midReset.dir", 32'(currentDirection), 32'd0);
        check("midReset.moveDoor", 32'({move, doorState}), 32'd0);
        check("midReset.clears", 32'({clearFloor, clearInternal}), 32'd0);
        reset = 1'b0;
        internalButton = '0;
        tbFloor = 1;
        tick();

        internalButton[3] = 1'b1;
        nextDirection = 2'b11;
        sawMove = 1'b0;
        repeat (8) begin tick(); sawMove = sawMove | move; end
        check("fault.set", 32'(fault), 32'd1);
        check("fault.dirStop", 32'(currentDirection), 32'd0);
        check("fault.noMove", 32'(sawMove), 32'd0);
        nextDirection = 2'b00;
        repeat (4) tick();
        check("fault.sticky", 32'(fault), 32'd1);
        check("fault.floor", 32'(currentFloor), 32'd1);
        internalButton = '0;
        reset = 1'b1;
        tick();
        check("fault.clearedByReset", 32'(fault), 32'd0);
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
